// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle processor control unit.
// Holds opcodes, ALU operation codes, datapath select codes and FSM states.
// Pure declarations: no latency, no flow control.
package control_fsm_pkg;

   // Instruction opcodes (IR[15:12]); 7..E are undefined.
   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_LW    = 4'h2;
   localparam logic [3:0] OP_SW    = 4'h3;
   localparam logic [3:0] OP_BEQ   = 4'h4;
   localparam logic [3:0] OP_BLT   = 4'h5;
   localparam logic [3:0] OP_J     = 4'h6;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // ALU operation codes; R-type funct uses the same encoding.
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLL = 3'd5;
   localparam logic [2:0] ALU_SRL = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   // ALU operand A selects.
   localparam logic [1:0] SRCA_PC   = 2'd0;
   localparam logic [1:0] SRCA_TWO  = 2'd1;
   localparam logic [1:0] SRCA_A    = 2'd2;
   localparam logic [1:0] SRCA_ZERO = 2'd3;

   // ALU operand B selects.
   localparam logic [1:0] SRCB_B    = 2'd0;
   localparam logic [1:0] SRCB_TWO  = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_ZERO = 2'd3;

   // PC source selects.
   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

   // Controller states.
   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_WB_ALU   = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WB   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12,
      S_ILLEGAL  = 4'd13
   } state_t;

   // Dispatch target after DECODE for a given opcode.
   function automatic state_t decode_target(input logic [3:0] opcode);
      state_t st;
      case (opcode)
         OP_RTYPE:      st = S_EXEC_R;
         OP_ADDI:       st = S_EXEC_I;
         OP_LW, OP_SW:  st = S_MEM_ADDR;
         OP_BEQ, OP_BLT: st = S_BRANCH;
         OP_J:          st = S_JUMP;
         OP_HALT:       st = S_HALT;
         default:       st = S_ILLEGAL;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/control_fsm_alu_op_decoder.sv
// ALU operation select derived from controller state, opcode and funct.
// Purely combinational, zero latency.
// No flow control; follows the state register every cycle.
module alu_op_decoder
   import control_fsm_pkg::*;
(
   input  state_t     i_state,
   input  logic [3:0] i_opcode,
   input  logic [2:0] i_funct,
   output logic [2:0] o_alu_op
);

   // Only EXEC_R uses funct and BRANCH compares by subtraction; all else adds.
   always_comb begin
      o_alu_op = ALU_ADD;
      case (i_state)
         S_EXEC_R: o_alu_op = (i_opcode == OP_RTYPE) ? i_funct : ALU_ADD;
         S_BRANCH: o_alu_op = ALU_SUB;
         default:  o_alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Moore control FSM sequencing fetch/decode/execute/memory/write-back, plus retire counter.
// Outputs decode from state in the same cycle; retire count visible one cycle after Retire.
// Waits in FETCH/MEM_RD/MEM_WR while input_MemReady is low, holding requests stable.
module control_fsm
   import control_fsm_pkg::*;
#(
   parameter int PC_STEP = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       input_Opcode,
   input  logic [2:0]       input_Funct,
   input  logic             input_Zero,
   input  logic             input_Negative,
   input  logic             input_MemReady,
   output logic             output_PCWrite,
   output logic             output_IRWrite,
   output logic             output_IorD,
   output logic             output_MemRead,
   output logic             output_MemWrite,
   output logic             output_RegWrite,
   output logic             output_RegDst,
   output logic             output_MemToReg,
   output logic [1:0]       output_ALUSrcA,
   output logic [1:0]       output_ALUSrcB,
   output logic [2:0]       output_ALUOp,
   output logic             output_PCSrc,
   output logic             output_Retire,
   output logic [CNT_W-1:0] output_InstrCount,
   output logic             output_Halted,
   output logic             output_Illegal
);

   // The datapath's PC increment is hard-wired to select code 1 (constant 2).
   if (PC_STEP != 2) begin : g_pc_step_check
      $error("control_fsm: datapath only supports PC_STEP = 2");
   end

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_count;

   // State register; reset parks in IDLE so every output drops immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state sequencing.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     w_next = S_FETCH;
         S_FETCH:    w_next = input_MemReady ? S_DECODE : S_FETCH;
         S_DECODE:   w_next = decode_target(input_Opcode);
         S_EXEC_R:   w_next = S_WB_ALU;
         S_EXEC_I:   w_next = S_WB_ALU;
         S_WB_ALU:   w_next = S_FETCH;
         S_MEM_ADDR: w_next = (input_Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   w_next = input_MemReady ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB:   w_next = S_FETCH;
         S_MEM_WR:   w_next = input_MemReady ? S_FETCH : S_MEM_WR;
         S_BRANCH:   w_next = S_FETCH;
         S_JUMP:     w_next = S_FETCH;
         S_HALT:     w_next = S_HALT;
         S_ILLEGAL:  w_next = S_ILLEGAL;
         default:    w_next = S_IDLE;
      endcase
   end

   // Output decode from the state; ready and flags only gate enables.
   always_comb begin
      output_PCWrite  = 1'b0;
      output_IRWrite  = 1'b0;
      output_IorD     = 1'b0;
      output_MemRead  = 1'b0;
      output_MemWrite = 1'b0;
      output_RegWrite = 1'b0;
      output_RegDst   = 1'b0;
      output_MemToReg = 1'b0;
      output_ALUSrcA  = SRCA_PC;
      output_ALUSrcB  = SRCB_B;
      output_PCSrc    = PCSRC_ALU;
      output_Retire   = 1'b0;
      output_Halted   = 1'b0;
      output_Illegal  = 1'b0;
      case (r_state)
         S_FETCH: begin
            output_MemRead = 1'b1;
            output_ALUSrcB = SRCB_TWO;
            output_IRWrite = input_MemReady;
            output_PCWrite = input_MemReady;
         end
         S_DECODE: begin
            output_ALUSrcB = SRCB_IMM;
         end
         S_EXEC_R: begin
            output_ALUSrcA = SRCA_A;
            output_ALUSrcB = SRCB_B;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            output_ALUSrcA = SRCA_A;
            output_ALUSrcB = SRCB_IMM;
         end
         S_WB_ALU: begin
            output_RegWrite = 1'b1;
            output_RegDst   = (input_Opcode == OP_RTYPE);
            output_Retire   = 1'b1;
         end
         S_MEM_RD: begin
            output_MemRead = 1'b1;
            output_IorD    = 1'b1;
         end
         S_MEM_WB: begin
            output_RegWrite = 1'b1;
            output_MemToReg = 1'b1;
            output_Retire   = 1'b1;
         end
         S_MEM_WR: begin
            output_MemWrite = 1'b1;
            output_IorD     = 1'b1;
            output_Retire   = input_MemReady;
         end
         S_BRANCH: begin
            output_ALUSrcA = SRCA_A;
            output_ALUSrcB = SRCB_B;
            output_PCSrc   = PCSRC_ALUOUT;
            output_Retire  = 1'b1;
            output_PCWrite = ((input_Opcode == OP_BEQ) && input_Zero) ||
                             ((input_Opcode == OP_BLT) && input_Negative);
         end
         S_JUMP: begin
            output_ALUSrcA = SRCA_ZERO;
            output_ALUSrcB = SRCB_IMM;
            output_PCWrite = 1'b1;
            output_Retire  = 1'b1;
         end
         S_HALT:    output_Halted  = 1'b1;
         S_ILLEGAL: output_Illegal = 1'b1;
         default: ;
      endcase
   end

   alu_op_decoder u_alu_op_decoder (
      .i_state  (r_state),
      .i_opcode (input_Opcode),
      .i_funct  (input_Funct),
      .o_alu_op (output_ALUOp)
   );

   // Retired-instruction counter; wraps naturally at full width.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              r_count <= '0;
      else if (output_Retire) r_count <= r_count + CNT_ONE;
   end

   assign output_InstrCount = r_count;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-cycle expected outputs queued by stimulus.
// Expected vectors come from an instruction-level model of each instruction's phases.
// Monitor pops one expectation per cycle on the falling edge and compares.
module tb_control_fsm;

   localparam int CNT_W = 8;

   typedef struct packed {
      logic             pcw, irw, iord, mr, mw, rw, rdst, m2r;
      logic [1:0]       srca, srcb;
      logic [2:0]       aluop;
      logic             pcsrc, retire, halted, illegal;
      logic [CNT_W-1:0] cnt;
   } out_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [3:0]       opcode = '0;
   logic [2:0]       funct = '0;
   logic             zero = 1'b0, neg = 1'b0, ready = 1'b0;
   logic             pcw, irw, iord, mr, mw, rw, rdst, m2r, pcsrc, retire, halted, illegal;
   logic [1:0]       srca, srcb;
   logic [2:0]       aluop;
   logic [CNT_W-1:0] cnt;

   out_t q[$];
   int   n_checks = 0;
   int   n_fails  = 0;
   int   model_cnt = 0;
   int   cyc = 0;
   bit   stim_done = 0;

   always #5 clk = ~clk;

   control_fsm #(.PC_STEP(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .input_Opcode(opcode), .input_Funct(funct),
      .input_Zero(zero), .input_Negative(neg), .input_MemReady(ready),
      .output_PCWrite(pcw), .output_IRWrite(irw), .output_IorD(iord),
      .output_MemRead(mr), .output_MemWrite(mw), .output_RegWrite(rw),
      .output_RegDst(rdst), .output_MemToReg(m2r),
      .output_ALUSrcA(srca), .output_ALUSrcB(srcb), .output_ALUOp(aluop),
      .output_PCSrc(pcsrc), .output_Retire(retire),
      .output_InstrCount(cnt), .output_Halted(halted), .output_Illegal(illegal)
   );

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic out_t blank();
      out_t e;
      e = '0;
      return e;
   endfunction

   // One cycle: drive inputs, queue the expected outputs, advance past the edge.
   task automatic step(input out_t e, input bit rdy, input bit z, input bit n);
      ready = rdy;
      zero  = z;
      neg   = n;
      e.cnt = CNT_W'(model_cnt % (1 << CNT_W));
      q.push_back(e);
      if (e.retire) model_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      out_t e;
      e = blank();
      reset = 1'b1;
      model_cnt = 0;
      repeat (n) step(e, rb(), rb(), rb());
      reset = 1'b0;
      step(e, rb(), rb(), rb());   // IDLE cycle
   endtask

   // Instruction-level model: expected per-cycle outputs for one instruction.
   task automatic run_instr(input logic [3:0] op, input logic [2:0] fn,
                            input int fw, input int mwait, input bit bz, input bit bn,
                            input int term_cycles);
      out_t e;
      opcode = op;
      funct  = fn;
      // fetch: wait cycles then the ready cycle that loads IR and PC
      e = blank(); e.mr = 1; e.srcb = 2'd1;
      repeat (fw) step(e, 1'b0, rb(), rb());
      e.irw = 1; e.pcw = 1;
      step(e, 1'b1, rb(), rb());
      // decode: branch target computed as PC + imm
      e = blank(); e.srcb = 2'd2;
      step(e, rb(), rb(), rb());
      case (op)
         4'h0, 4'h1: begin
            e = blank(); e.srca = 2'd2;
            e.srcb  = (op == 4'h0) ? 2'd0 : 2'd2;
            e.aluop = (op == 4'h0) ? fn : 3'd0;
            step(e, rb(), rb(), rb());
            e = blank(); e.rw = 1; e.rdst = (op == 4'h0); e.retire = 1;
            step(e, rb(), rb(), rb());
         end
         4'h2: begin
            e = blank(); e.srca = 2'd2; e.srcb = 2'd2;
            step(e, rb(), rb(), rb());
            e = blank(); e.mr = 1; e.iord = 1;
            repeat (mwait) step(e, 1'b0, rb(), rb());
            step(e, 1'b1, rb(), rb());
            e = blank(); e.rw = 1; e.m2r = 1; e.retire = 1;
            step(e, rb(), rb(), rb());
         end
         4'h3: begin
            e = blank(); e.srca = 2'd2; e.srcb = 2'd2;
            step(e, rb(), rb(), rb());
            e = blank(); e.mw = 1; e.iord = 1;
            repeat (mwait) step(e, 1'b0, rb(), rb());
            e.retire = 1;
            step(e, 1'b1, rb(), rb());
         end
         4'h4, 4'h5: begin
            e = blank(); e.srca = 2'd2; e.srcb = 2'd0; e.aluop = 3'd1;
            e.pcsrc = 1; e.retire = 1;
            e.pcw = (op == 4'h4) ? bz : bn;
            step(e, rb(), bz, bn);
         end
         4'h6: begin
            e = blank(); e.srca = 2'd3; e.srcb = 2'd2; e.pcw = 1; e.retire = 1;
            step(e, rb(), rb(), rb());
         end
         default: begin
            e = blank();
            if (op == 4'hF) e.halted = 1; else e.illegal = 1;
            repeat (term_cycles) begin
               opcode = 4'($urandom_range(0, 15));
               funct  = 3'($urandom_range(0, 7));
               step(e, rb(), rb(), rb());
            end
         end
      endcase
   endtask

   // Monitor: one expectation consumed per cycle, compared away from the edge.
   initial begin
      out_t a, x;
      forever begin
         @(negedge clk);
         cyc++;
         if (q.size() != 0) begin
            x = q.pop_front();
            a = {pcw, irw, iord, mr, mw, rw, rdst, m2r, srca, srcb, aluop,
                 pcsrc, retire, halted, illegal, cnt};
            n_checks++;
            if (a !== x) begin
               n_fails++;
               $display("FAIL outputs cycle %0d: got %h expected %h", cyc, a, x);
            end
         end
      end
   end

   initial begin
      int op_i, fw, mwait;
      out_t e;
      @(posedge clk);
      #1;
      do_reset(3);

      // directed: R-type ADD, LW with 3 wait cycles, branches, jump
      run_instr(4'h0, 3'd0, 0, 0, 0, 0, 0);
      run_instr(4'h2, 3'd5, 0, 3, 0, 0, 0);
      run_instr(4'h4, 3'd0, 0, 0, 1, 0, 0);
      run_instr(4'h4, 3'd0, 0, 0, 0, 1, 0);
      run_instr(4'h5, 3'd0, 0, 0, 0, 1, 0);
      run_instr(4'h5, 3'd0, 0, 0, 1, 0, 0);
      run_instr(4'h6, 3'd0, 0, 0, 0, 0, 0);
      run_instr(4'h3, 3'd0, 2, 2, 0, 0, 0);

      // random legal stream; more than 2^CNT_W retires so the counter wraps
      repeat (320) begin
         op_i  = $urandom_range(0, 6);
         fw    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         mwait = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         run_instr(4'(op_i), 3'($urandom_range(0, 7)), fw, mwait, rb(), rb(), 0);
      end

      // reset asserted during WB_ALU of an R-type: outputs drop before any edge
      opcode = 4'h0; funct = 3'd3;
      e = blank(); e.mr = 1; e.srcb = 2'd1; e.irw = 1; e.pcw = 1;
      step(e, 1'b1, 0, 0);
      e = blank(); e.srcb = 2'd2;
      step(e, 1'b1, 0, 0);
      e = blank(); e.srca = 2'd2; e.aluop = 3'd3;
      step(e, 1'b1, 0, 0);
      do_reset(2);

      // illegal opcode is terminal
      run_instr(4'h9, 3'd0, 1, 0, 0, 0, 12);
      do_reset(1);
      // HALT is terminal
      run_instr(4'hF, 3'd0, 0, 0, 0, 0, 12);
      do_reset(1);
      run_instr(4'h1, 3'd2, 0, 0, 0, 0, 0);
      stim_done = 1;
   end

   initial begin
      int budget;
      budget = 60000;
      while (!(stim_done && q.size() == 0) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      #2;
      n_checks++;
      if (budget == 0) begin
         n_fails++;
         $display("FAIL timeout: pending %0d expectations, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
